// File: rtl/qracc_pkg.sv
// qracc_pkg: shared types and defaults for the QR accelerator SRAM sequencer.
// Holds the sequencer state enum and the default phase lengths in cycles.
package qracc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PCH,
    WL_WR,
    WL_RD,
    SENSE,
    RECOVER,
    RESP
  } sram_seq_state_t;

  localparam int SRAM_PCH_CYCLES = 2;
  localparam int SRAM_WL_CYCLES  = 2;
  localparam int SRAM_SA_CYCLES  = 1;

endpackage

// File: rtl/sram_wl_decoder.sv
// sram_wl_decoder: registered one-hot wordline driver for the bit-cell array.
// Ports: clk, rst (async high), en, addr in; wl one-hot out (zero if addr out of range).
module sram_wl_decoder #(
  parameter int numRows = 128,
  parameter int aw      = $clog2(numRows)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [aw-1:0]      addr,
  output logic [numRows-1:0] wl
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wl <= '0;
    end else begin
      wl <= '0;
      if (en && (32'(addr) < numRows)) wl[addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/sram_rw_sequencer.sv
// sram_rw_sequencer: turns one SRAM request at a time into the timed
// precharge / wordline / write / column-select / sense sequence.
// Ports: clk, rst (async high); request side rq_valid_i, rq_wr_i, addr_i,
// wr_data_i, rq_ready_o, rd_valid_o, rd_data_o; mac_busy_i blocks acceptance;
// array side WL_o, PCH_o, WRITE_o, WR_DATA_o, CSEL_o, SAEN_o, SA_OUT_i; wr_err_o.
// Optional macro SRAM_RW_WRITE_VERIFY_EN adds a read-back check after each write.
module sram_rw_sequencer
  import qracc_pkg::*;
#(
  parameter int numRows   = 128,
  parameter int numCols   = 32,
  parameter int pchCycles = SRAM_PCH_CYCLES,
  parameter int wlCycles  = SRAM_WL_CYCLES,
  parameter int saCycles  = SRAM_SA_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rq_valid_i,
  input  logic                       rq_wr_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  input  logic                       mac_busy_i,
  output logic [numRows-1:0]         WL_o,
  output logic                       PCH_o,
  output logic                       WRITE_o,
  output logic [numCols-1:0]         WR_DATA_o,
  output logic [numCols-1:0]         CSEL_o,
  output logic                       SAEN_o,
  input  logic [numCols-1:0]         SA_OUT_i,
  output logic                       wr_err_o
);

  localparam int AW = $clog2(numRows);

  sram_seq_state_t    state;
  sram_seq_state_t    nxt;
  logic [7:0]         cnt;
  logic [7:0]         len_m1;
  logic               last;
  logic [AW-1:0]      addr_q;
  logic [numCols-1:0] data_q;
  logic               wr_q;
  logic               vfy_q;
  logic               in_range;
  logic               wl_en;
  logic               csel_nxt;

`ifdef SRAM_RW_WRITE_VERIFY_EN
  localparam bit VfyEn = 1'b1;

  // vfy_q marks the internal read-back pass that follows a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vfy_q    <= 1'b0;
      wr_err_o <= 1'b0;
    end else begin
      wr_err_o <= 1'b0;
      if (state == IDLE) vfy_q <= 1'b0;
      else if (state == RECOVER && nxt == PCH) vfy_q <= 1'b1;
      if (state == SENSE && last && vfy_q)
        wr_err_o <= (SA_OUT_i != data_q);
    end
  end
`else
  localparam bit VfyEn = 1'b0;
  assign vfy_q    = 1'b0;
  assign wr_err_o = 1'b0;
`endif

  assign in_range   = 32'(addr_q) < numRows;
  assign rq_ready_o = (state == IDLE) && !mac_busy_i && !rst;

  always_comb begin
    len_m1 = '0;
    case (state)
      PCH:          len_m1 = 8'(pchCycles - 1);
      WL_WR, WL_RD: len_m1 = 8'(wlCycles - 1);
      SENSE:        len_m1 = 8'(saCycles - 1);
      default:      len_m1 = '0;
    endcase
  end

  assign last = (cnt == len_m1);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (rq_valid_i && rq_ready_o) nxt = PCH;
      PCH:     if (last) nxt = (wr_q && !vfy_q) ? WL_WR : WL_RD;
      WL_WR:   if (last) nxt = RECOVER;
      WL_RD:   if (last) nxt = SENSE;
      SENSE:   if (last) nxt = vfy_q ? RECOVER : RESP;
      RESP:    nxt = RECOVER;
      RECOVER: nxt = (VfyEn && wr_q && !vfy_q) ? PCH : IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign wl_en    = (nxt == WL_WR) || (nxt == WL_RD);
  assign csel_nxt = wl_en || (nxt == SENSE);

  // Outputs are decoded from the next state so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      PCH_o      <= 1'b0;
      WRITE_o    <= 1'b0;
      WR_DATA_o  <= '0;
      CSEL_o     <= '0;
      SAEN_o     <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt == state && state != IDLE) ? cnt + 8'd1 : 8'd0;
      if (state == IDLE && nxt == PCH) begin
        addr_q <= addr_i;
        data_q <= wr_data_i;
        wr_q   <= rq_wr_i;
      end
      PCH_o      <= (nxt == PCH);
      WRITE_o    <= (nxt == WL_WR);
      WR_DATA_o  <= (nxt == WL_WR) ? data_q : '0;
      CSEL_o     <= {numCols{csel_nxt}};
      SAEN_o     <= (nxt == SENSE);
      rd_valid_o <= (nxt == RESP);
      if (state == SENSE && last && !vfy_q)
        rd_data_o <= in_range ? SA_OUT_i : '0;
    end
  end

  sram_wl_decoder #(
    .numRows(numRows),
    .aw     (AW)
  ) u_wl_dec (
    .clk (clk),
    .rst (rst),
    .en  (wl_en),
    .addr(addr_q),
    .wl  (WL_o)
  );

endmodule

// File: doc/sram_rw_sequencer.md
# sram_rw_sequencer

Responder end of the SRAM request channel (`rq_valid_i`/`rq_wr_i`/`addr_i`/`wr_data_i` in, `rq_ready_o`/`rd_valid_o`/`rd_data_o` out) used to load and read back weights in the QR accelerator macro. It accepts one request at a time and expands it into the timed analog control sequence for the bit-cell array: precharge, wordline, write drivers, column select and sense-amp enable. It sits between the digital request port and the `to_analog`/`from_analog` signals. It yields the array to MAC operation whenever `mac_busy_i` is high.

## Interface
- `numRows`, 128, array rows; `addr_i` width is `$clog2(numRows)`
- `numCols`, 32, array columns; data width
- `pchCycles`, 2, precharge phase length, ≥1
- `wlCycles`, 2, wordline phase length, ≥1
- `saCycles`, 1, sense phase length, ≥1

- `clk`  in  1  clock; one clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `rq_valid_i`  in  1  request valid
- `rq_wr_i`  in  1  1 = write, 0 = read
- `addr_i`  in  `$clog2(numRows)`  row address
- `wr_data_i`  in  `numCols`  write data
- `rq_ready_o`  out  1  ready to accept a request
- `rd_valid_o`  out  1  one-cycle read-data strobe
- `rd_data_o`  out  `numCols`  read data, held until the next read completes
- `mac_busy_i`  in  1  array owned by the MAC path; blocks acceptance
- `WL_o`  out  `numRows`  one-hot wordlines
- `PCH_o`  out  1  bitline precharge, active-high
- `WRITE_o`  out  1  write-driver enable
- `WR_DATA_o`  out  `numCols`  write-driver data
- `CSEL_o`  out  `numCols`  column select
- `SAEN_o`  out  1  sense-amp enable
- `SA_OUT_i`  in  `numCols`  sense-amp outputs
- `wr_err_o`  out  1  write-verify mismatch pulse (see Configuration)

## Operation
- States: IDLE, PCH, WL_WR, WL_RD, SENSE, RECOVER, RESP.
- IDLE: `rq_ready_o = !mac_busy_i`. A request is accepted on the edge where `rq_valid_i && rq_ready_o` is true. On acceptance, latch `addr_i`, `wr_data_i` and `rq_wr_i`, then go to PCH.
- PCH: `PCH_o = 1` for `pchCycles` cycles. Then go to WL_WR if the request is a write, WL_RD if it is a read.
- WL_WR: drive `WL_o[addr] = 1`, `WRITE_o = 1`, `WR_DATA_o = latched data` and `CSEL_o = all-ones` for `wlCycles` cycles. Then go to RECOVER.
- WL_RD: drive `WL_o[addr] = 1` and `CSEL_o = all-ones` for `wlCycles` cycles. Then go to SENSE.
- SENSE: `SAEN_o = 1` and `CSEL_o = all-ones` for `saCycles` cycles. `WL_o` is 0 in this state. Capture `SA_OUT_i` on the last SENSE cycle, then go to RESP.
- RESP: `rd_valid_o = 1` for exactly one cycle with the captured data. Then go to RECOVER.
- RECOVER: all array controls are 0 for one cycle. Then go to IDLE.
- Every output is a registered state decode, so no output glitches.
- Invariants:
  - `WL_o` is one-hot or zero.
  - `PCH_o` is never high in the same cycle as any `WL_o` bit or `SAEN_o`.
  - `WRITE_o` and `SAEN_o` are never both high.
- Address `≥ numRows` (only possible when `numRows` is not a power of 2): the full sequence still runs with no WL asserted. A read returns 0.
- `mac_busy_i` rising during an access: the access completes normally. The block then stays in IDLE with ready low until `mac_busy_i` falls.
- `rq_valid_i` held high after acceptance is ignored until IDLE is re-entered. This allows an initiator that drops valid one cycle after seeing ready.

## Timing
- Reset values:
  - All outputs are 0, including `rd_data_o`.
  - State is IDLE, so `rq_ready_o` follows `!mac_busy_i` from the first cycle after reset is released.
  - Asserting `rst` mid-access forces every array control low immediately (asynchronous); the access is lost.
- Write: acceptance edge T. PCH occupies T+1…T+pchCycles, then WL_WR, then RECOVER. `rq_ready_o` is high again at T+pchCycles+wlCycles+2, which is 6 cycles with default parameters.
- Read: `rd_valid_o` is high at T+pchCycles+wlCycles+saCycles+1, which is T+6 with defaults. `rq_ready_o` is high again two cycles after that.
- `rq_ready_o` is low from the cycle after acceptance until the return to IDLE.

## Configuration
- `SRAM_RW_WRITE_VERIFY_EN` defined:
  - After a write's RECOVER, the block runs an internal read of the same address (PCH → WL_RD → SENSE) with no `rd_valid_o` pulse and no update of `rd_data_o`.
  - It compares the sensed data with the latched write data. `wr_err_o` pulses for one cycle on mismatch.
  - The block then passes through RECOVER to IDLE. Write latency grows by pchCycles+wlCycles+saCycles+1.
- Macro undefined: `wr_err_o` is tied to 0 and the verify path is not synthesized.

## Structure
- `qracc_pkg` gains:
  - `sram_seq_state_t`, the state enum;
  - the default timing constants `SRAM_PCH_CYCLES`, `SRAM_WL_CYCLES`, `SRAM_SA_CYCLES`.
- Sub-module `sram_wl_decoder`: row address plus enable → registered one-hot `WL_o`, driving zero for out-of-range addresses.

## Test plan
- Reset, then write addr 5 with data 0xA5A5_0F0F → PCH high 2 cycles, `WL_o[5]` and `WRITE_o` high 2 cycles, `WR_DATA_o = 0xA5A5_0F0F`, ready returns 6 cycles after acceptance.
- Read addr 5 with array model echoing stored data → `rd_valid_o` pulses at T+6 with `rd_data_o = 0xA5A5_0F0F`, held afterwards.
- `mac_busy_i = 1` with `rq_valid_i = 1` → `rq_ready_o` stays 0 and no array activity occurs. Dropping `mac_busy_i` → accepted next edge.
- Assert `rst` during WL_RD → all array outputs 0 in the same cycle, `rd_valid_o` never pulses, ready reappears after release.
- Sweep all 128 addresses, each a write then a read → checker confirms one-hot WL, no PCH/WL overlap, data matches.
- With `SRAM_RW_WRITE_VERIFY_EN`, model a stuck-at-0 on column 3 and write 0xFFFF_FFFF → `wr_err_o` pulses once and `rd_valid_o` stays 0.
